// File: rtl/mul_accum.sv
// Multiply-accumulate run controller: sums N_SAMPLES products arriving LAT cycles after their operands.
// Optional feature macro MUL_ACCUM_SAT_EN: saturate sum on overflow instead of wrapping.
module mul_accum #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4,
    parameter int LAT       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       p,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    output logic             busy,
    output logic             ovf,
    output logic [1:0]       dbg_state_o
);

    localparam int               CNT_W  = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] launch_q, launch_d;
    logic [CNT_W-1:0] accept_q, accept_d;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             sum_valid_q;
    logic             busy_q;

    logic             launch;
    logic             accept;
    logic [ACC_W:0]   add_full;

    // in_valid has no backpressure: an operand pair counts only on the cycle it is
    // high while RUN still has launches left; its product must be on p exactly LAT
    // cycles later, when the matching delay-line bit reaches the output.
    assign launch   = in_valid && (state_q == S_RUN) && (launch_q < N_LAST);
    assign accept   = vld_q[LAT-1] && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign add_full = {1'b0, sum_q} + {{(ACC_W-3){1'b0}}, p};

    generate
        if (LAT == 1) begin : g_lat1
            assign vld_d = launch;
        end else begin : g_latn
            assign vld_d = {vld_q[LAT-2:0], launch};
        end
    endgenerate

    always_comb begin
        launch_d = launch_q;
        accept_d = accept_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        if (launch) begin
            launch_d = launch_q + 1'b1;
        end
        if (accept) begin
            accept_d = accept_q + 1'b1;
            if (add_full[ACC_W]) begin
                ovf_d = 1'b1;
`ifdef MUL_ACCUM_SAT_EN
                // Once clamped, every further add carries again, so sum stays at max.
                sum_d = '1;
`else
                sum_d = add_full[ACC_W-1:0];
`endif
            end else begin
                sum_d = add_full[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            launch_q    <= '0;
            accept_q    <= '0;
            vld_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            sum_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        sum_q    <= '0;
                        ovf_q    <= 1'b0;
                        launch_q <= '0;
                        accept_q <= '0;
                    end
                end
                S_RUN: begin
                    launch_q <= launch_d;
                    accept_q <= accept_d;
                    sum_q    <= sum_d;
                    ovf_q    <= ovf_d;
                    if (launch && (launch_d == N_LAST)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    accept_q <= accept_d;
                    sum_q    <= sum_d;
                    ovf_q    <= ovf_d;
                    if (accept && (accept_d == N_LAST)) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        sum_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sum         = sum_q;
    assign sum_valid   = sum_valid_q;
    assign busy        = busy_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_accum.sv
// Bench for mul_accum: directed operand tables, corner sequences, randomized runs against a
// transaction-level model, and a long run on a second instance for overflow behaviour.
module tb_mul_accum;

    localparam int ACC_W = 8;
    localparam int N     = 4;
    localparam int LAT   = 4;
    localparam int N2    = 32;
    localparam int LAT2  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [3:0]       p = 4'd0;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             busy;
    logic             ovf;
    logic [1:0]       dbg_state;

    logic             start2 = 1'b0;
    logic             iv2 = 1'b0;
    logic [3:0]       p2 = 4'd0;
    logic [ACC_W-1:0] sum2;
    logic             sum_valid2;
    logic             busy2;
    logic             ovf2;
    logic [1:0]       dbg_state2;

    always #5 clk = ~clk;

    mul_accum #(.ACC_W(ACC_W), .N_SAMPLES(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .p(p),
        .sum(sum), .sum_valid(sum_valid), .busy(busy), .ovf(ovf), .dbg_state_o(dbg_state)
    );

    mul_accum #(.ACC_W(ACC_W), .N_SAMPLES(N2), .LAT(LAT2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(iv2), .p(p2),
        .sum(sum2), .sum_valid(sum_valid2), .busy(busy2), .ovf(ovf2), .dbg_state_o(dbg_state2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Final {ovf, sum} of a run whose products add up to total.
    function automatic logic [ACC_W:0] final_of(input int total);
        int lim;
        lim = 1 << ACC_W;
`ifdef MUL_ACCUM_SAT_EN
        if (total >= lim) return {1'b1, {ACC_W{1'b1}}};
`endif
        return {(total >= lim) ? 1'b1 : 1'b0, ACC_W'(total % lim)};
    endfunction

    // Upstream multiplier: product of cycle k appears on p in cycle k+LAT.
    logic       hv[0:LAT];
    logic [3:0] hp[0:LAT];

    // Transaction model: 0 idle, 1 collecting operands, 2 waiting for the result.
    int               cyc = 0;
    int               m_phase = 0;
    int               m_cnt = 0;
    int               m_total = 0;
    int               m_done_cyc = 0;
    logic [ACC_W:0]   m_fin = '0;
    logic             e_busy = 1'b0;
    logic             e_sv = 1'b0;
    logic             e_known = 1'b1;
    logic [ACC_W-1:0] e_sum = '0;
    logic             e_ovf = 1'b0;
    logic [ACC_W:0]   exp_q[$];

    int               sv_count = 0;
    logic [ACC_W-1:0] last_sum = '0;
    logic             last_ovf = 1'b0;

    task automatic cycle(input logic st, input logic iv, input logic [1:0] a, input logic [1:0] b);
        logic [ACC_W:0] fin;
        logic           started;
        @(posedge clk);
        #1;
        check("busy", busy, e_busy);
        check("sum_valid", sum_valid, e_sv);
        if (e_known) begin
            check("sum", sum, e_sum);
            check("ovf", ovf, e_ovf);
        end
        if (sum_valid) begin
            sv_count++;
            last_sum = sum;
            last_ovf = ovf;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_sum_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                fin = exp_q.pop_front();
                check("final_sum", sum, fin[ACC_W-1:0]);
                check("final_ovf", ovf, fin[ACC_W]);
            end
        end

        start    = st;
        in_valid = iv;
        for (int i = LAT; i > 0; i--) begin
            hv[i] = hv[i-1];
            hp[i] = hp[i-1];
        end
        hv[0] = iv;
        hp[0] = 4'(a) * 4'(b);
        p     = hv[LAT] ? hp[LAT] : 4'($urandom_range(0, 15));

        started = 1'b0;
        if (m_phase == 0 && st) begin
            m_phase = 1;
            m_cnt   = 0;
            m_total = 0;
            started = 1'b1;
        end else if (m_phase == 1 && iv) begin
            m_total += int'(a) * int'(b);
            m_cnt++;
            if (m_cnt == N) begin
                m_phase    = 2;
                m_done_cyc = cyc + LAT + 1;
                m_fin      = final_of(m_total);
                exp_q.push_back(m_fin);
            end
        end else if (m_phase == 2 && cyc == m_done_cyc) begin
            m_phase = 0;
        end
        e_busy = (m_phase == 1) || (m_phase == 2 && cyc + 1 < m_done_cyc);
        e_sv   = (m_phase == 2) && (cyc + 1 == m_done_cyc);
        if (started) begin
            e_known = 1'b1;
            e_sum   = '0;
            e_ovf   = 1'b0;
        end else if (e_sv) begin
            e_known = 1'b1;
            e_sum   = m_fin[ACC_W-1:0];
            e_ovf   = m_fin[ACC_W];
        end else if (m_phase != 0) begin
            e_known = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset(input int hold);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        #2;
        check("rst_sum", sum, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dbg_state, 0);
        repeat (hold) @(posedge clk);
        #2;
        check("rst_hold_sum_valid", sum_valid, 0);
        check("rst_hold_busy", busy, 0);
        rst     = 1'b0;
        m_phase = 0;
        e_busy  = 1'b0;
        e_sv    = 1'b0;
        e_known = 1'b1;
        e_sum   = '0;
        e_ovf   = 1'b0;
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        int               gap;
        logic [ACC_W-1:0] exp_sum;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int               sv0;
        int               cnt2;
        logic [ACC_W-1:0] s2;
        logic             o2;
        logic [ACC_W:0]   f2;

        // Operand pair i sits in bits [2i+1:2i]; expected sums worked out by hand.
        vecs[0] = '{a: 8'hFF, b: 8'hFF, gap: 0, exp_sum: 8'd36, exp_ovf: 1'b0};
        vecs[1] = '{a: 8'hA4, b: 8'hE4, gap: 2, exp_sum: 8'd11, exp_ovf: 1'b0};
        vecs[2] = '{a: 8'h1F, b: 8'hEB, gap: 1, exp_sum: 8'd17, exp_ovf: 1'b0};
        vecs[3] = '{a: 8'hAA, b: 8'hFF, gap: 3, exp_sum: 8'd24, exp_ovf: 1'b0};
        vecs[4] = '{a: 8'h79, b: 8'h57, gap: 0, exp_sum: 8'd9,  exp_ovf: 1'b0};

        for (int i = 0; i <= LAT; i++) begin
            hv[i] = 1'b0;
            hp[i] = 4'd0;
        end

        #1;
        do_reset(3);

        for (int v = 0; v < 5; v++) begin
            sv0 = sv_count;
            cycle(1'b1, 1'b0, 2'd0, 2'd0);
            for (int i = 0; i < 4; i++) begin
                cycle(1'b0, 1'b1, vecs[v].a[2*i +: 2], vecs[v].b[2*i +: 2]);
                for (int g = 0; g < vecs[v].gap; g++)
                    cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
            for (int w = 0; w < 20 && sv_count == sv0; w++) cycle(1'b0, 1'b0, 2'd0, 2'd0);
            repeat (3) cycle(1'b0, 1'b0, 2'd0, 2'd0);
            check("vec_strobes", sv_count - sv0, 1);
            check("vec_sum", last_sum, vecs[v].exp_sum);
            check("vec_ovf", last_ovf, vecs[v].exp_ovf);
            check("vec_busy_after", busy, 0);
        end

        // Six operand pulses with a second start inside the run: only the first four count.
        sv0 = sv_count;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, 2'd3, 2'd3);
        cycle(1'b1, 1'b1, 2'd2, 2'd2);
        cycle(1'b0, 1'b1, 2'd1, 2'd3);
        cycle(1'b0, 1'b1, 2'd3, 2'd1);
        cycle(1'b1, 1'b1, 2'd3, 2'd3);
        cycle(1'b0, 1'b1, 2'd3, 2'd3);
        repeat (LAT + 8) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        check("extra_strobes", sv_count - sv0, 1);
        check("extra_sum", last_sum, 19);

        // Reset after two products have been accumulated abandons the run.
        sv0 = sv_count;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        repeat (4) cycle(1'b0, 1'b1, 2'd3, 2'd3);
        repeat (2) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        cycle(1'b0, 1'b0, 2'd0, 2'd0);
        check("mid_run_sum", sum, 18);
        do_reset(2);
        repeat (10) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        check("rst_no_strobe", sv_count - sv0, 0);
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        repeat (4) cycle(1'b0, 1'b1, 2'd3, 2'd3);
        repeat (LAT + 4) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        check("post_rst_strobes", sv_count - sv0, 1);
        check("post_rst_sum", last_sum, 36);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 2000; k++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (k % 450 == 449) do_reset(1 + $urandom_range(0, 2));
        end
        repeat (LAT + 4) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        check("rand_queue_drained", exp_q.size(), 0);

        // Long run on the second instance: 32 products of 9 overflow an 8-bit sum.
        f2   = final_of(9 * N2);
        cnt2 = 0;
        s2   = '0;
        o2   = 1'b0;
        p2   = 4'd9;
        @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        check("run2_busy", busy2, 1);
        start2 = 1'b0;
        iv2    = 1'b1;
        for (int w = 0; w < 60; w++) begin
            @(posedge clk);
            #1;
            if (sum_valid2) begin
                cnt2++;
                s2 = sum2;
                o2 = ovf2;
            end
            iv2 = (w < N2 - 1);
        end
        check("run2_strobes", cnt2, 1);
        check("run2_sum", s2, f2[ACC_W-1:0]);
        check("run2_ovf", o2, f2[ACC_W]);
        check("run2_hold_sum", sum2, f2[ACC_W-1:0]);
        check("run2_busy_after", busy2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 8, accumulator/sum width in bits (legal range 5..16).
REQ-002 SHALL have parameter N_SAMPLES, default 4, number of products summed per run (legal range 1..255).
REQ-003 SHALL have parameter LAT, default 4, upstream multiplier latency in cycles from operands valid to product valid (legal range 1..8).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse beginning a run.
REQ-007 SHALL have port in_valid  input  1  operands presented to the 2-bit multiplier this cycle.
REQ-008 SHALL have port p  input  4  unsigned product from the multiplier, valid LAT cycles after its in_valid.
REQ-009 SHALL have port sum  output  ACC_W  accumulated sum of the run.
REQ-010 SHALL have port sum_valid  output  1  one-cycle strobe: sum is final.
REQ-011 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag for the current run.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 SHALL clear sum, ovf, launch count and accept count, and go to RUN next cycle.
REQ-015 SHALL keep an LAT-deep valid delay line; a bit enters it only when in_valid=1, state=RUN and launch count < N_SAMPLES.
REQ-016 Each entered in_valid SHALL increment the launch count; when the count reaches N_SAMPLES the FSM SHALL go to DRAIN.
REQ-017 in_valid outside RUN, or beyond N_SAMPLES launches, SHALL be ignored (not delayed, not summed).
REQ-018 When the delay-line output is 1, p SHALL be zero-extended and added to sum on that edge, and accept count incremented.
REQ-019 When accept count reaches N_SAMPLES, the FSM SHALL go to DONE; DONE SHALL last exactly one cycle with sum_valid=1, then return to IDLE.
REQ-020 Aligned products SHALL be accumulated in RUN as well as DRAIN (LAT < N_SAMPLES case).
REQ-021 sum SHALL hold its final value from DONE until the next accepted start.
REQ-022 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-023 An addition with carry out of ACC_W bits SHALL set ovf; ovf SHALL remain set until the next accepted start.
REQ-024 busy SHALL be high exactly in RUN and DRAIN.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, sum=0, sum_valid=0, busy=0, ovf=0, clear all counters and the valid delay line.
REQ-026 rst asserted mid-run SHALL abandon the run; no sum_valid SHALL follow release.
REQ-027 First start after rst release SHALL be accepted normally.

Configuration
REQ-028 Macro MUL_ACCUM_SAT_EN defined: on overflow sum SHALL clamp to 2^ACC_W-1 and stay there for the run; ovf set.
REQ-029 Macro MUL_ACCUM_SAT_EN undefined: sum SHALL wrap modulo 2^ACC_W; ovf set.

Verification
REQ-030 Defaults; start, then in_valid on 4 consecutive cycles with a=3,b=3 (p=9) -> sum=36, sum_valid one cycle, ovf=0, busy low after.
REQ-031 Defaults; products 0,1,4,6 with gaps of 2 idle cycles between in_valid -> sum=11, exactly one sum_valid.
REQ-032 N_SAMPLES=32, p=9 every cycle; without MUL_ACCUM_SAT_EN -> sum=32, ovf=1; with it -> sum=255, ovf=1.
REQ-033 Defaults; 6 in_valid pulses and a second start during RUN -> only first 4 summed, second start ignored, one sum_valid.
REQ-034 Defaults; rst pulsed after 2 products accepted -> all outputs 0 during rst, no sum_valid; next run with p=9 x4 -> sum=36.
